dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Sits between the cpu's data-memory port (SC/LC/DMEMaddr/Data_in/CS/DM_W/DM_R/Dataout) and a word-wide, byte-enabled data RAM with variable latency.
- Converts byte, half and word loads/stores into aligned word accesses over a req/ack handshake.
- Stalls the pipeline until each access completes, then returns sign- or zero-extended load data.
- Replaces the zero-wait DMEM path so slower or shared memories can attach.

Parameters:
ADDR_W, 11, RAM word-address width (2^ADDR_W words).
BASE_ADDR, 32'h1001_0000, CPU byte address mapped to RAM word 0.
TIMEOUT, 16, max cycles waiting for ram_ack before abort (≥2).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
CS  input  1  cpu memory select
DM_W  input  1  store request (qualified by CS)
DM_R  input  1  load request (qualified by CS)
SC  input  2  store size: 00 none, 01 word, 10 half, 11 byte
LC  input  3  load type: 000 none, 001 lw, 010 lh, 011 lhu, 100 lb, 101 lbu
DMEMaddr  input  32  cpu byte address
Data_in  input  32  store data, right-justified
Dataout  output  32  extended load data to cpu
mem_stall  output  1  holds cpu pipeline while high
bus_err  output  1  one-cycle pulse on timeout or misalignment trap
ram_req  output  1  RAM request, held until ack
ram_we  output  1  1 = write, 0 = read
ram_be  output  4  byte enables, bit i = bits [8i+7:8i]
ram_addr  output  ADDR_W  word address
ram_wdata  output  32  lane-positioned write data
ram_rdata  input  32  RAM read data, valid in the ram_ack cycle
ram_ack  input  1  RAM completion, single-cycle pulse

Behaviour:
- Reset (async, active-high): state IDLE. Dataout=0, ram_req=0, ram_we=0, ram_be=0, ram_addr=0, ram_wdata=0, bus_err=0, timeout counter=0.
- Access valid = CS & (DM_R | DM_W). DM_W has priority if both are high. A write with SC=00 or a read with LC=000/110/111 is a no-op: no stall, no RAM access.
- Offset = DMEMaddr - BASE_ADDR (32-bit wrap). ram_addr = offset[ADDR_W+1:2]; upper bits are ignored (aliasing).
- Store lanes:
  - word: be=1111, wdata=Data_in.
  - half: be = offset[1] ? 1100 : 0011; wdata = {2{Data_in[15:0]}}.
  - byte: be = 0001 << offset[1:0]; wdata = {4{Data_in[7:0]}}.
- Loads: be=1111. The lane is selected from captured rdata by offset[1:0] (half uses offset[1]). lh/lb sign-extend; lhu/lbu zero-extend.
- FSM:
  - IDLE: on a valid access, register ram_addr/be/wdata/we, set ram_req=1, go to WAIT. mem_stall is combinationally high in this same cycle.
  - WAIT: mem_stall=1, ram_req=1, counter increments each cycle.
    - ram_ack=1: for a read, capture the extended result into Dataout. Drop ram_req, go to DONE.
    - Counter reaches TIMEOUT-1 without ack: drop ram_req, Dataout=0, pulse bus_err, go to DONE.
  - DONE: mem_stall=0 for exactly one cycle; the cpu advances on this edge. Go to IDLE; the counter clears.
- Minimum latency: ack in the first WAIT cycle → 2 stall cycles + DONE.
- Dataout holds its last load value until the next completed load.
- ram_ack in IDLE or DONE is ignored.
- Request inputs are sampled only in IDLE; changes during WAIT are ignored.
- Ack arriving in the same cycle the counter expires counts as success (no bus_err).
- Reset during WAIT aborts immediately: ram_req drops asynchronously and no write completes from the controller's side.

Optional Feature:
MISALIGN_TRAP_EN:
- Defined: a half access with offset[0]=1, or a word access with offset[1:0]≠0, issues no RAM request. The FSM goes IDLE→DONE (one stall cycle), pulses bus_err, and loads return Dataout=0.
- Undefined: low address bits are ignored for word accesses and offset[0] is ignored for halves (forced alignment); no trap.

Test Plan:
- sw 0xDEADBEEF at 0x10010004, ack after 3 cycles → ram_addr=1, be=1111, wdata=DEADBEEF; mem_stall high 4 cycles, then low 1 cycle; bus_err=0.
- sb Data_in=0x000000A5 at 0x10010007 → be=1000, wdata=A5A5A5A5, ram_addr=1.
- lb at 0x10010007 with ram_rdata=0x80FF7F01 → Dataout=FFFFFF80; lbu → 00000080; lh at 0x10010006 → FFFF80FF; lhu → 000080FF.
- lw with no ram_ack → ram_req drops after 16 WAIT cycles, bus_err pulses once, Dataout=0, mem_stall releases.
- Reset asserted mid-WAIT → ram_req=0 and Dataout=0 immediately; a later lw completes normally.
- With MISALIGN_TRAP_EN, lw at 0x10010002 → no ram_req, bus_err pulse, one stall cycle; without it → ram_addr=0 word read.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: bridges the cpu data-memory port onto a word-wide,
// byte-enabled RAM with a req/ack handshake and variable latency.
// Byte/half/word stores are lane-positioned; loads are sign/zero extended.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses trap
// (bus_err, no RAM request) instead of being force-aligned.
module dmem_access_ctrl #(
    parameter int unsigned ADDR_W    = 11,
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CS,
    input  logic              DM_W,
    input  logic              DM_R,
    input  logic [1:0]        SC,
    input  logic [2:0]        LC,
    input  logic [31:0]       DMEMaddr,
    input  logic [31:0]       Data_in,
    output logic [31:0]       Dataout,
    output logic              mem_stall,
    output logic              bus_err,
    output logic              ram_req,
    output logic              ram_we,
    output logic [3:0]        ram_be,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic              ram_ack
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ram_req_q, ram_req_d;
    logic                ram_we_q, ram_we_d;
    logic [3:0]          ram_be_q, ram_be_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [31:0]         ram_wdata_q, ram_wdata_d;
    logic [31:0]         dout_q, dout_d;
    logic                bus_err_q, bus_err_d;
    logic [2:0]          lc_q, lc_d;
    logic [1:0]          off_q, off_d;

    logic [31:0]         offset;
    logic                acc_word, acc_half, acc_byte, acc_go, misalign;
    logic [3:0]          be_new;
    logic [31:0]         wdata_new;
    logic [15:0]         half_sel;
    logic [7:0]          byte_sel;
    logic [31:0]         load_ext;
    logic                stall;

    // Request decode: size, lane enables, positioned write data, misalignment.
    always_comb begin
        offset   = DMEMaddr - BASE_ADDR;
        acc_word = 1'b0;
        acc_half = 1'b0;
        acc_byte = 1'b0;
        if (DM_W) begin
            case (SC)
                2'b01:   acc_word = 1'b1;
                2'b10:   acc_half = 1'b1;
                2'b11:   acc_byte = 1'b1;
                default: ;
            endcase
        end else begin
            case (LC)
                3'b001:         acc_word = 1'b1;
                3'b010, 3'b011: acc_half = 1'b1;
                3'b100, 3'b101: acc_byte = 1'b1;
                default:        ;
            endcase
        end
        acc_go    = CS & (DM_R | DM_W) & (acc_word | acc_half | acc_byte);
        be_new    = 4'b1111;
        wdata_new = Data_in;
        if (DM_W && acc_half) begin
            be_new    = offset[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{Data_in[15:0]}};
        end else if (DM_W && acc_byte) begin
            be_new    = 4'b0001 << offset[1:0];
            wdata_new = {4{Data_in[7:0]}};
        end
`ifdef MISALIGN_TRAP_EN
        misalign = (acc_half & offset[0]) | (acc_word & (offset[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
    end

    // Lane select and extension of the acked read word.
    always_comb begin
        half_sel = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (off_q)
            2'd0:    byte_sel = ram_rdata[7:0];
            2'd1:    byte_sel = ram_rdata[15:8];
            2'd2:    byte_sel = ram_rdata[23:16];
            default: byte_sel = ram_rdata[31:24];
        endcase
        case (lc_q)
            3'b010:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b011:  load_ext = {16'h0000, half_sel};
            3'b100:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b101:  load_ext = {24'h000000, byte_sel};
            default: load_ext = ram_rdata;
        endcase
    end

    // Next-state logic: IDLE issues, WAIT holds request until ack/timeout, DONE releases.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_be_d    = ram_be_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        dout_d      = dout_q;
        lc_d        = lc_q;
        off_d       = off_q;
        bus_err_d   = 1'b0;
        stall       = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (acc_go) begin
                    stall = 1'b1;
                    if (misalign) begin
                        state_d   = S_DONE;
                        bus_err_d = 1'b1;
                        if (!DM_W) dout_d = '0;
                    end else begin
                        state_d     = S_WAIT;
                        ram_req_d   = 1'b1;
                        ram_we_d    = DM_W;
                        ram_be_d    = be_new;
                        ram_wdata_d = wdata_new;
                        ram_addr_d  = offset[ADDR_W+1:2];
                        lc_d        = LC;
                        off_d       = offset[1:0];
                    end
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                // An ack in the expiry cycle wins over the timeout.
                if (ram_ack) begin
                    ram_req_d = 1'b0;
                    if (!ram_we_q) dout_d = load_ext;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    ram_req_d = 1'b0;
                    dout_d    = '0;
                    bus_err_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_be_q    <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            dout_q      <= '0;
            bus_err_q   <= 1'b0;
            lc_q        <= '0;
            off_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_be_q    <= ram_be_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            dout_q      <= dout_d;
            bus_err_q   <= bus_err_d;
            lc_q        <= lc_d;
            off_q       <= off_d;
        end
    end

    assign Dataout   = dout_q;
    assign mem_stall = stall;
    assign bus_err   = bus_err_q;
    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_be    = ram_be_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed steps followed by random accesses
// checked against a byte-addressed reference memory.
module tb_dmem_access_ctrl;

    localparam int unsigned ADDR_W  = 11;
    localparam logic [31:0] BASE    = 32'h1001_0000;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned NBYTES  = 4 << ADDR_W;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              CS, DM_W, DM_R;
    logic [1:0]        SC;
    logic [2:0]        LC;
    logic [31:0]       DMEMaddr, Data_in, Dataout;
    logic              mem_stall, bus_err, ram_req, ram_we, ram_ack;
    logic [3:0]        ram_be;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata, ram_rdata;

    logic [31:0] ram    [0:(1<<ADDR_W)-1];
    logic [7:0]  refmem [0:NBYTES-1];
    logic [31:0] rsp_word;
    int          ack_delay;
    bit          spurious;
    int          wait_cnt;

    int checks = 0;
    int errors = 0;

    int          obs_stall, obs_req;
    logic        obs_err, obs_err_next, obs_stall_next, obs_req_any, obs_we;
    logic [31:0] obs_dout, obs_wdata, obs_addr;
    logic [3:0]  obs_be;

    dmem_access_ctrl #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .CS(CS), .DM_W(DM_W), .DM_R(DM_R),
        .SC(SC), .LC(LC), .DMEMaddr(DMEMaddr), .Data_in(Data_in),
        .Dataout(Dataout), .mem_stall(mem_stall), .bus_err(bus_err),
        .ram_req(ram_req), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack)
    );

    always #5 clk = ~clk;

    // RAM responder: acks the ack_delay-th request cycle (0 = never ack).
    always @(negedge clk) begin
        ram_ack = 1'b0;
        if (ram_req) begin
            wait_cnt++;
            if (ack_delay != 0 && wait_cnt == ack_delay) begin
                ram_ack   = 1'b1;
                ram_rdata = ram[ram_addr];
                if (ram_we) begin
                    rsp_word = ram[ram_addr];
                    for (int i = 0; i < 4; i++)
                        if (ram_be[i]) rsp_word[8*i +: 8] = ram_wdata[8*i +: 8];
                    ram[ram_addr] = rsp_word;
                end
            end
        end else begin
            wait_cnt = 0;
            if (spurious) begin
                ram_ack   = 1'b1;
                ram_rdata = 32'hC3C3_5A5A;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Reference load: bytes gathered from the byte memory, extended arithmetically.
    function automatic logic [31:0] ref_load(input logic [2:0] lc, input int unsigned off);
        int unsigned w, h;
        int          v;
        w = off - (off % 4);
        h = off - (off % 2);
        case (lc)
            3'd2: begin v = refmem[h] + 256 * refmem[h+1]; if (v >= 32768) v = v - 65536; return 32'(v); end
            3'd3: return 32'(refmem[h] + 256 * refmem[h+1]);
            3'd4: begin v = refmem[off]; if (v >= 128) v = v - 256; return 32'(v); end
            3'd5: return 32'(refmem[off]);
            default: return {refmem[w+3], refmem[w+2], refmem[w+1], refmem[w]};
        endcase
    endfunction

    task automatic ref_store(input logic [1:0] sc, input int unsigned off, input logic [31:0] din);
        int unsigned w, h;
        w = off - (off % 4);
        h = off - (off % 2);
        case (sc)
            2'd1: for (int i = 0; i < 4; i++) refmem[w+i] = din[8*i +: 8];
            2'd2: begin refmem[h] = din[7:0]; refmem[h+1] = din[15:8]; end
            2'd3: refmem[off] = din[7:0];
            default: ;
        endcase
    endtask

    // One cpu access, observed cycle by cycle until the stall releases.
    task automatic do_acc(input logic cs, input logic w, input logic r, input logic [1:0] sc,
                          input logic [2:0] lc, input logic [31:0] addr, input logic [31:0] din,
                          input int delay);
        bit done;
        @(negedge clk);
        ack_delay = delay;
        CS = cs; DM_W = w; DM_R = r; SC = sc; LC = lc; DMEMaddr = addr; Data_in = din;
        obs_stall = 0; obs_req = 0; obs_req_any = 1'b0; done = 1'b0;
        for (int n = 0; n < 60 && !done; n++) begin
            #1;
            obs_req_any = obs_req_any | ram_req;
            if (mem_stall) begin
                obs_stall++;
                if (ram_req) begin
                    obs_req++;
                    obs_addr = 32'(ram_addr); obs_be = ram_be; obs_wdata = ram_wdata; obs_we = ram_we;
                end
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        obs_err  = bus_err;
        obs_dout = Dataout;
        CS = 1'b0; DM_W = 1'b0; DM_R = 1'b0;
        @(negedge clk);
        #1;
        obs_err_next   = bus_err;
        obs_stall_next = mem_stall;
        obs_req_any    = obs_req_any | ram_req;
    endtask

    initial begin
        logic [31:0] exp_dout;
        logic        cs, w, r, valid, misal;
        logic [1:0]  sc;
        logic [2:0]  lc;
        logic [31:0] addr, din;
        int unsigned off, sz;
        int          d;

        reset = 1'b1; CS = 1'b0; DM_W = 1'b0; DM_R = 1'b0; SC = '0; LC = '0;
        DMEMaddr = '0; Data_in = '0; ram_ack = 1'b0; ram_rdata = '0;
        ack_delay = 1; spurious = 1'b0; wait_cnt = 0;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            ram[i] = $urandom;
            for (int b = 0; b < 4; b++) refmem[4*i+b] = ram[i][8*b +: 8];
        end
        #2;
        chk("rst_dout", Dataout, 32'h0);
        chk("rst_req", ram_req, 1'b0);
        chk("rst_we", ram_we, 1'b0);
        chk("rst_be", ram_be, 4'h0);
        chk("rst_addr", 32'(ram_addr), 32'h0);
        chk("rst_wdata", ram_wdata, 32'h0);
        chk("rst_err", bus_err, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // sw DEADBEEF, ack on third wait cycle
        do_acc(1, 1, 0, 2'b01, 3'b000, BASE + 4, 32'hDEADBEEF, 3);
        ref_store(2'b01, 4, 32'hDEADBEEF);
        chk("sw_stall", obs_stall, 4); chk("sw_reqcyc", obs_req, 3);
        chk("sw_addr", obs_addr, 1); chk("sw_be", obs_be, 4'b1111);
        chk("sw_wdata", obs_wdata, 32'hDEADBEEF); chk("sw_we", obs_we, 1'b1);
        chk("sw_err", obs_err, 1'b0); chk("sw_release", obs_stall_next, 1'b0);

        // sb A5 into top lane
        do_acc(1, 1, 0, 2'b11, 3'b000, BASE + 7, 32'h0000_00A5, 1);
        ref_store(2'b11, 7, 32'h0000_00A5);
        chk("sb_stall", obs_stall, 2); chk("sb_addr", obs_addr, 1);
        chk("sb_be", obs_be, 4'b1000); chk("sb_wdata", obs_wdata, 32'hA5A5A5A5);

        do_acc(1, 0, 1, 2'b00, 3'b001, BASE + 4, 32'h0, 2);
        chk("lw_merge", obs_dout, 32'hA5AD_BEEF); chk("lw_be", obs_be, 4'b1111);
        chk("lw_we", obs_we, 1'b0); chk("lw_stall", obs_stall, 3);

        // sh lower lane, then restore test word
        do_acc(1, 1, 0, 2'b10, 3'b000, BASE + 4, 32'h1234_5678, 1);
        ref_store(2'b10, 4, 32'h1234_5678);
        chk("sh_be", obs_be, 4'b0011); chk("sh_wdata", obs_wdata, 32'h5678_5678);
        do_acc(1, 1, 0, 2'b01, 3'b000, BASE + 4, 32'h80FF_7F01, 1);
        ref_store(2'b01, 4, 32'h80FF_7F01);

        do_acc(1, 0, 1, 2'b00, 3'b100, BASE + 7, 32'h0, 1); chk("lb", obs_dout, 32'hFFFF_FF80);
        do_acc(1, 0, 1, 2'b00, 3'b101, BASE + 7, 32'h0, 1); chk("lbu", obs_dout, 32'h0000_0080);
        do_acc(1, 0, 1, 2'b00, 3'b010, BASE + 6, 32'h0, 1); chk("lh", obs_dout, 32'hFFFF_80FF);
        do_acc(1, 0, 1, 2'b00, 3'b011, BASE + 6, 32'h0, 1); chk("lhu", obs_dout, 32'h0000_80FF);
        do_acc(1, 0, 1, 2'b00, 3'b100, BASE + 4, 32'h0, 1); chk("lb_lane0", obs_dout, 32'h0000_0001);

        // ack while idle must be ignored
        spurious = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("spur_stall", mem_stall, 1'b0); chk("spur_dout", Dataout, 32'h0000_0001);
        end
        spurious = 1'b0;

        // reset in the middle of a wait
        @(negedge clk);
        ack_delay = 0; CS = 1'b1; DM_R = 1'b1; DM_W = 1'b0; LC = 3'b001; DMEMaddr = BASE + 4;
        repeat (3) @(negedge clk);
        #1 chk("mid_req", ram_req, 1'b1);
        reset = 1'b1;
        #1 chk("abort_req", ram_req, 1'b0); chk("abort_dout", Dataout, 32'h0);
        CS = 1'b0; DM_R = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        do_acc(1, 0, 1, 2'b00, 3'b001, BASE + 4, 32'h0, 1);
        chk("post_rst_lw", obs_dout, 32'h80FF_7F01); chk("post_rst_stall", obs_stall, 2);

        // no ack at all: timeout after TIMEOUT wait cycles
        do_acc(1, 0, 1, 2'b00, 3'b001, BASE + 8, 32'h0, 0);
        chk("to_stall", obs_stall, TIMEOUT + 1); chk("to_reqcyc", obs_req, TIMEOUT);
        chk("to_err", obs_err, 1'b1); chk("to_err_once", obs_err_next, 1'b0);
        chk("to_dout", obs_dout, 32'h0);

        // ack in the expiry cycle is a success
        do_acc(1, 0, 1, 2'b00, 3'b001, BASE + 4, 32'h0, TIMEOUT);
        chk("late_err", obs_err, 1'b0); chk("late_dout", obs_dout, 32'h80FF_7F01);
        chk("late_stall", obs_stall, TIMEOUT + 1);

        // misaligned word load
        do_acc(1, 0, 1, 2'b00, 3'b001, BASE + 2, 32'h0, 1);
        if (TRAP_EN) begin
            chk("mis_stall", obs_stall, 1); chk("mis_req", obs_req_any, 1'b0);
            chk("mis_err", obs_err, 1'b1); chk("mis_dout", obs_dout, 32'h0);
            exp_dout = 32'h0;
        end else begin
            chk("mis_addr", obs_addr, 0); chk("mis_be", obs_be, 4'b1111);
            chk("mis_err", obs_err, 1'b0); chk("mis_dout", obs_dout, ref_load(3'b001, 0));
            exp_dout = ref_load(3'b001, 0);
        end

        // no-op requests
        do_acc(1, 1, 0, 2'b00, 3'b000, BASE + 4, 32'hFFFF_FFFF, 1);
        chk("nop_sc_stall", obs_stall, 0); chk("nop_sc_req", obs_req_any, 1'b0);
        do_acc(1, 0, 1, 2'b00, 3'b110, BASE + 4, 32'h0, 1);
        chk("nop_lc_stall", obs_stall, 0); chk("nop_lc_dout", obs_dout, exp_dout);
        do_acc(0, 0, 1, 2'b00, 3'b001, BASE + 4, 32'h0, 1);
        chk("nop_cs_stall", obs_stall, 0); chk("nop_cs_req", obs_req_any, 1'b0);

        // random accesses against the byte-memory model
        for (int k = 0; k < 200; k++) begin
            cs  = ($urandom_range(0, 9) != 0);
            w   = 1'($urandom_range(0, 1));
            r   = w ? 1'($urandom_range(0, 1)) : 1'b1;
            sc  = 2'($urandom_range(0, 3));
            lc  = 3'($urandom_range(0, 7));
            off = $urandom_range(0, 127);
            addr = BASE + off + ($urandom_range(0, 3) * NBYTES);
            din = $urandom;
            d   = ($urandom_range(0, 7) == 0) ? TIMEOUT : $urandom_range(1, 4);
            valid = cs & (w | r);
            if (w) sz = (sc == 2'd1) ? 4 : (sc == 2'd2) ? 2 : (sc == 2'd3) ? 1 : 0;
            else   sz = (lc == 3'd1) ? 4 : (lc == 3'd2 || lc == 3'd3) ? 2 : (lc == 3'd4 || lc == 3'd5) ? 1 : 0;
            misal = TRAP_EN && ((sz == 2 && off % 2 != 0) || (sz == 4 && off % 4 != 0));
            do_acc(cs, w, r, sc, lc, addr, din, d);
            if (!valid || sz == 0) begin
                chk("rnd_nop_stall", obs_stall, 0);
                chk("rnd_nop_req", obs_req_any, 1'b0);
            end else if (misal) begin
                if (!w) exp_dout = 32'h0;
                chk("rnd_trap_stall", obs_stall, 1);
                chk("rnd_trap_err", obs_err, 1'b1);
            end else begin
                chk("rnd_stall", obs_stall, d + 1);
                chk("rnd_err", obs_err, 1'b0);
                chk("rnd_addr", obs_addr, off / 4);
                chk("rnd_we", obs_we, w);
                if (w) ref_store(sc, off, din);
                else   exp_dout = ref_load(lc, off);
            end
            chk("rnd_dout", obs_dout, exp_dout);
            chk("rnd_err_next", obs_err_next, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
